// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared types and defaults for the handshake responder
package hs_pkg;

  // Handshake FSM: IDLE waits for a request, ACK holds acknowledge until it falls
  typedef enum logic [0:0] {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_t;

  localparam int HS_DATA_W_DEF = 8;

endpackage

// File: rtl/hs_fifo.sv
// rtl/hs_fifo.sv - synchronous first-word-fall-through register FIFO
module hs_fifo
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W_DEF,
  parameter int DEPTH  = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_W-1:0]          wdata_i,
  output logic [DATA_W-1:0]          rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so a push into a full FIFO is legal alongside it
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage is cleared on reset so the head word reads zero afterwards
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; level tracks occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/hs_responder.sv
// rtl/hs_responder.sv - four-phase req/ack destination endpoint with output stream FIFO
module hs_responder
  import hs_pkg::*;
#(
  parameter int DATA_W = HS_DATA_W_DEF,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic [DATA_W-1:0]          data_i,
  output logic                       ack_o,
  output logic [DATA_W-1:0]          m_data_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic [CNT_W-1:0]           xfer_cnt_o
);

  hs_state_t        state_q, state_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic             accept;
  logic             pop;
  logic             space;
  logic             fifo_empty, fifo_full;

  assign pop   = m_valid_o && m_ready_i;
  assign space = !fifo_full || pop;

  hs_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (data_i),
    .rdata_o (m_data_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level_o)
  );

  assign m_valid_o  = !fifo_empty;
  assign ack_o      = (state_q == HS_ACK);
  assign xfer_cnt_o = xfer_cnt_q;

  // Next state: accept only from IDLE with room, then hold ACK until the request drops
  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    xfer_cnt_d = xfer_cnt_q;
    case (state_q)
      HS_IDLE: begin
        if (req_i && space) begin
          accept     = 1'b1;
          xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
          state_d    = HS_ACK;
        end
      end
      HS_ACK: begin
        if (!req_i) state_d = HS_IDLE;
      end
      default: state_d = HS_IDLE;
    endcase
  end

  // State and transfer counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= HS_IDLE;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

endmodule

// File: tb/tb_hs_responder.sv
// tb/tb_hs_responder.sv - self-checking bench for hs_responder against a queue model
module tb_hs_responder;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int CNT_W  = 4;
  localparam int LVL_W  = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              req_i = 1'b0;
  logic [DATA_W-1:0] data_i = '0;
  logic              m_ready_i = 1'b0;
  logic              ack_o;
  logic [DATA_W-1:0] m_data_o;
  logic              m_valid_o;
  logic [LVL_W-1:0]  level_o;
  logic [CNT_W-1:0]  xfer_cnt_o;

  hs_responder #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_i      (req_i),
    .data_i     (data_i),
    .ack_o      (ack_o),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .level_o    (level_o),
    .xfer_cnt_o (xfer_cnt_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: an acknowledge flag, a queue of stored words, and a modulo counter
  bit           m_ack = 1'b0;
  byte unsigned m_q[$];
  int           m_cnt = 0;
  bit           rand_ready = 1'b0;
  byte unsigned got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the model on current inputs, then compare every output after the edge
  task automatic step();
    bit pop, space, accept, was_rst;
    if (rand_ready) m_ready_i = 1'($urandom_range(0, 1));
    if (!rst_i && m_valid_o === 1'b1 && m_ready_i) got.push_back(m_data_o);
    was_rst = rst_i;
    if (rst_i) begin
      m_ack = 1'b0;
      m_q.delete();
      m_cnt = 0;
    end else begin
      pop    = (m_q.size() > 0) && m_ready_i;
      space  = (m_q.size() < DEPTH) || pop;
      accept = !m_ack && req_i && space;
      if (pop) void'(m_q.pop_front());
      if (accept) begin
        m_q.push_back(data_i);
        m_ack = 1'b1;
        m_cnt = (m_cnt + 1) % (1 << CNT_W);
      end else if (m_ack && !req_i) begin
        m_ack = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("ack", 32'(ack_o), 32'(m_ack));
    chk("valid", 32'(m_valid_o), 32'(m_q.size() != 0));
    chk("level", 32'(level_o), 32'(m_q.size()));
    chk("cnt", 32'(xfer_cnt_o), 32'(m_cnt));
    if (m_q.size() > 0) chk("data", 32'(m_data_o), 32'(m_q[0]));
    else if (was_rst) chk("rst_data", 32'(m_data_o), 32'h0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_i = 1'b0;
    step();
    step();
    rst_i = 1'b0;
  endtask

  // Source side of the four-phase handshake, bounded on both phases
  task automatic handshake(input logic [DATA_W-1:0] d);
    bit ok = 1'b0;
    req_i  = 1'b1;
    data_i = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      step();
      if (ack_o === 1'b1) ok = 1'b1;
    end
    if (!ok) chk("hs_ack_timeout", 32'(ack_o), 32'h1);
    req_i = 1'b0;
    for (int i = 0; i < 200 && ack_o !== 1'b0; i++) step();
    if (ack_o !== 1'b0) chk("hs_rel_timeout", 32'(ack_o), 32'h0);
  endtask

  initial begin
    // Single transfer
    do_reset();
    m_ready_i = 1'b1;
    step(); step(); step();
    req_i = 1'b1; data_i = 8'hA5;
    step();
    chk("single_ack", 32'(ack_o), 32'h1);
    chk("single_data", 32'(m_data_o), 32'hA5);
    step(); step();
    req_i = 1'b0;
    step();
    chk("single_rel", 32'(ack_o), 32'h0);
    chk("single_cnt", 32'(xfer_cnt_o), 32'h1);

    // Back-pressure
    do_reset();
    m_ready_i = 1'b0;
    handshake(8'h01);
    handshake(8'h02);
    chk("bp_level", 32'(level_o), 32'h2);
    req_i = 1'b1; data_i = 8'h03;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("bp_hold", 32'(ack_o), 32'h0);
    end
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;
    chk("bp_ack", 32'(ack_o), 32'h1);
    chk("bp_head", 32'(m_data_o), 32'h02);
    chk("bp_level2", 32'(level_o), 32'h2);
    req_i = 1'b0;
    step();
    m_ready_i = 1'b1;
    step(); step(); step();

    // Ordering under random back-pressure
    do_reset();
    got.delete();
    rand_ready = 1'b1;
    for (int i = 0; i < 8; i++) handshake(8'(8'h10 + i));
    rand_ready = 1'b0;
    m_ready_i = 1'b1;
    step(); step(); step(); step();
    chk("ord_count", 32'(got.size()), 32'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("ord_word", 32'(got[i]), 32'(8'h10 + i));
    chk("ord_cnt", 32'(xfer_cnt_o), 32'd8);

    // Data change while acknowledged
    do_reset();
    m_ready_i = 1'b0;
    req_i = 1'b1; data_i = 8'h33;
    step();
    data_i = 8'h44;
    step(); step(); step();
    chk("chg_level", 32'(level_o), 32'h1);
    req_i = 1'b0;
    step(); step();
    chk("chg_head", 32'(m_data_o), 32'h33);
    chk("chg_level2", 32'(level_o), 32'h1);

    // Reset while acknowledged with a full FIFO
    do_reset();
    m_ready_i = 1'b0;
    handshake(8'h55);
    req_i = 1'b1; data_i = 8'h66;
    step();
    chk("rm_pre_ack", 32'(ack_o), 32'h1);
    chk("rm_pre_level", 32'(level_o), 32'h2);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("rm_ack", 32'(ack_o), 32'h0);
    chk("rm_valid", 32'(m_valid_o), 32'h0);
    chk("rm_level", 32'(level_o), 32'h0);
    chk("rm_cnt", 32'(xfer_cnt_o), 32'h0);
    step();
    chk("rm_reaccept", 32'(ack_o), 32'h1);
    chk("rm_reaccept_data", 32'(m_data_o), 32'h66);
    req_i = 1'b0;
    step();

    // Counter wrap at 2^CNT_W
    do_reset();
    m_ready_i = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      handshake(8'($urandom));
      if (i == 16) chk("wrap16", 32'(xfer_cnt_o), 32'h0);
      if (i == 17) chk("wrap17", 32'(xfer_cnt_o), 32'h1);
    end

    // Random traffic with random consumer
    do_reset();
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      handshake(8'($urandom));
      for (int k = $urandom_range(0, 3); k > 0; k--) step();
    end
    rand_ready = 1'b0;
    m_ready_i = 1'b1;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hs_responder.md
# hs_responder

Destination-side endpoint of the four-phase req/ack handshake. Lives in the receive clock domain, downstream of the req/data synchronizer. It accepts a word when the synchronized request is high, raises the acknowledge, and returns it low once the request falls. Accepted words are queued in a small FIFO and presented as a valid/ready stream, so the acknowledge is never issued for a word that cannot be stored.

## Interface
- DATA_W, 8, width of handshake data and output stream.
- DEPTH, 2, output FIFO entries; power of two, ≥2.
- CNT_W, 16, width of the accepted-transfer counter.

- clk_i  in  1  sole clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  request, already synchronized into clk_i.
- data_i  in  DATA_W  handshake data; stable whenever req_i=1.
- ack_o  out  1  acknowledge to source (through the return synchronizer).
- m_data_o  out  DATA_W  head-of-FIFO word.
- m_valid_o  out  1  FIFO non-empty.
- m_ready_i  in  1  consumer takes m_data_o when m_valid_o & m_ready_i.
- level_o  out  $clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- xfer_cnt_o  out  CNT_W  accepted words since reset; wraps.

## Operation
- FSM states:
  - HS_IDLE: ack_o=0.
  - HS_ACK: ack_o=1.
- HS_IDLE:
  - Transition to HS_ACK when req_i=1 and space is available.
  - On that edge, push data_i and increment xfer_cnt_o.
  - Otherwise remain in HS_IDLE.
- Space available when level < DEPTH, or when a pop occurs the same cycle (level==DEPTH and m_valid_o & m_ready_i).
- HS_ACK:
  - Transition to HS_IDLE on the edge where req_i=0.
  - While req_i=1, remain in HS_ACK. No further pushes occur, even if data_i changes.
- ack_o is a registered decode of state; there is no combinational path from req_i to ack_o.
- FIFO:
  - First-word-fall-through: m_data_o is the head entry, and is don't-care when empty.
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Push and pop in the same cycle leave level unchanged.
- xfer_cnt_o wraps from 2^CNT_W-1 to 0.
- Reset (rst_i=1 at an edge), regardless of state:
  - state=HS_IDLE, ack_o=0.
  - FIFO emptied: m_valid_o=0, level_o=0.
  - xfer_cnt_o=0.
  - m_data_o=0.
  - Reset has priority over push and pop.
- If req_i is still high after reset, the word is accepted again. The system must reset the source endpoint in the same window.

## Timing
- Push latency: req_i seen high at edge t with space → ack_o=1, m_valid_o=1, level_o+1, xfer_cnt_o+1, all visible after edge t.
- Release latency: req_i seen low at edge t in HS_ACK → ack_o=0 after edge t.
- Minimum handshake is 2 cycles of req_i high; one accepted word per 2 cycles at best.
- Back-pressure:
  - Full FIFO with m_ready_i=0 holds the FSM in HS_IDLE, ack_o stays 0, and req_i is left pending.
  - The first cycle m_ready_i=1 both pops and pushes.
- A pop visible at edge t lowers level_o after edge t.

## Structure
- Package hs_pkg:
  - hs_state_t enum {HS_IDLE, HS_ACK}.
  - HS_DATA_W_DEF=8.
- Sub-module hs_fifo (DATA_W, DEPTH):
  - Synchronous FWFT register FIFO.
  - Ports: push, pop, wdata, rdata, empty, full, level.
- hs_responder holds the FSM, counter, and hs_fifo instance.

## Test plan
- Single transfer:
  - Stimulus: reset, then req_i=1 with data_i=8'hA5 at cycle 5, and m_ready_i=1.
  - Response: ack_o=1 and m_data_o=A5/m_valid_o=1 from cycle 6. Drop req_i at cycle 8, and ack_o=0 from cycle 9. xfer_cnt_o=1.
- Back-pressure:
  - Stimulus: m_ready_i=0, then 3 handshakes with data 01, 02, 03.
  - Response: first two acked and level_o=2. Third req stays un-acked, with ack_o=0 for ≥10 cycles. Pulse m_ready_i=1 for one cycle: 01 pops, 03 pushes on the same edge, and ack_o rises next cycle.
- Ordering:
  - Stimulus: 8 back-to-back handshakes with data 10..17, m_ready_i toggling randomly.
  - Response: output order is exactly 10..17; xfer_cnt_o=8.
- Data change while acked:
  - Stimulus: data_i changes from 33 to 44 while in HS_ACK with req_i held high.
  - Response: only 33 is queued; level_o unchanged.
- Reset mid-operation:
  - Stimulus: assert rst_i for 1 cycle in HS_ACK with level_o=2.
  - Response: ack_o=0, m_valid_o=0, level_o=0, xfer_cnt_o=0 next cycle. With req_i still high, a new accept occurs the following cycle.
- Counter wrap:
  - Stimulus: CNT_W=4, 17 handshakes.
  - Response: xfer_cnt_o reads 0 after the 16th and 1 after the 17th.
